// File: rtl/shadow_dump_ctrl_pkg.sv
// Shared definitions for the shadow capture unload path: FSM encoding and
// word-count / configuration helpers evaluated at elaboration time.
package shadow_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT,
    ST_DUMP,
    ST_FLUSH
  } state_e;

  // Words needed to carry chain_len samples of size bits in out_w-bit words.
  function automatic int num_words(input int size, input int chain_len, input int out_w);
    return (chain_len * size + out_w - 1) / out_w;
  endfunction

  function automatic bit out_w_ok(input int size, input int out_w);
    return (size > 0) && (out_w >= size) && ((out_w % size) == 0);
  endfunction

endpackage

// File: rtl/shadow_word_packer.sv
// Packs chain samples LSB-first into OUT_W-bit words and holds them in a
// valid/ready output register; back-pressure stalls the accumulator.
module shadow_word_packer
  import shadow_dump_ctrl_pkg::*;
#(
  parameter int SIZE      = 1,
  parameter int CHAIN_LEN = 64,
  parameter int OUT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sample_en,
  input  logic [SIZE-1:0]  sample,
  input  logic             final_sample,
  output logic             acc_full,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last
);

  localparam int K      = OUT_W / SIZE;
  localparam int CW     = $clog2(K + 1);
  localparam int NWORDS = num_words(SIZE, CHAIN_LEN, OUT_W);
  localparam int WW     = $clog2(NWORDS + 1);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pend_q, pend_d;
  logic [WW-1:0]    words_q, words_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_last_q, dout_last_d;
  logic             complete_now;
  logic             load;

  always_comb begin
    // A fresh word starts from zero so a partial final word is zero-padded.
    acc_d = (count_q == '0) ? '0 : acc_q;
    for (int i = 0; i < K; i++) begin
      if (sample_en && (count_q == CW'(i))) acc_d[i*SIZE +: SIZE] = sample;
    end

    complete_now = sample_en && ((count_q == CW'(K - 1)) || final_sample);
    load         = (complete_now || pend_q) && (!dout_valid_q || dout_ready);

    count_d      = sample_en ? count_q + CW'(1) : count_q;
    pend_d       = pend_q;
    words_d      = words_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;

    if (load) begin
      count_d      = '0;
      pend_d       = 1'b0;
      dout_d       = complete_now ? acc_d : acc_q;
      dout_valid_d = 1'b1;
      dout_last_d  = (words_q == WW'(NWORDS - 1));
      words_d      = words_q + WW'(1);
    end else begin
      if (complete_now) pend_d = 1'b1;
      if (dout_ready) begin
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
      end
    end

    if (clr) begin
      count_d = '0;
      pend_d  = 1'b0;
      words_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      pend_q       <= 1'b0;
      words_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      pend_q       <= pend_d;
      words_q      <= words_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

  // Accumulator contents are only meaningful alongside count_q.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign acc_full   = (count_q == CW'(K));
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;

endmodule

// File: rtl/shadow_dump_ctrl.sv
// Unload controller for the shadow capture chain: capture pulse, wait for
// chain ready (with timeout), then shift the chain out into packed words.
module shadow_dump_ctrl
  import shadow_dump_ctrl_pkg::*;
#(
  parameter int SIZE      = 1,
  parameter int CHAIN_LEN = 64,
  parameter int OUT_W     = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             c_en,
  output logic             d_en,
  input  logic             chain_ready,
  input  logic [SIZE-1:0]  chain_out,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last
);

  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  if (!out_w_ok(SIZE, OUT_W)) begin : g_bad_cfg
    $error("shadow_dump_ctrl: OUT_W must be a multiple of SIZE");
  end

  state_e        state_q, state_d;
  logic [RW-1:0] remaining_q, remaining_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          acc_full;
  logic          last_hs;

  // Enables decode straight from registered state so reset kills them at once.
  assign c_en    = (state_q == ST_CAPTURE);
  assign d_en    = (state_q == ST_DUMP) && (remaining_q != '0) && !acc_full;
  assign busy    = (state_q != ST_IDLE);
  assign last_hs = dout_valid && dout_ready && dout_last;
  assign done    = done_q;
  assign err     = err_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tmr_d       = tmr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        tmr_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (chain_ready) begin
          remaining_d = RW'(CHAIN_LEN);
          state_d     = ST_DUMP;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_DUMP: begin
        // Leave on the final shift so DUMP spans exactly CHAIN_LEN shifts.
        if (d_en) begin
          remaining_d = remaining_q - RW'(1);
          if (remaining_q == RW'(1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (last_hs) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      tmr_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tmr_q       <= tmr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  shadow_word_packer #(
    .SIZE      (SIZE),
    .CHAIN_LEN (CHAIN_LEN),
    .OUT_W     (OUT_W)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr          (c_en),
    .sample_en    (d_en),
    .sample       (chain_out),
    .final_sample (remaining_q == RW'(1)),
    .acc_full     (acc_full),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_last    (dout_last)
  );

endmodule

// File: tb/tb_shadow_dump_ctrl.sv
// Directed bench for shadow_dump_ctrl with a behavioural chain model on two
// configurations (4-bit x8 into 16-bit words, 1-bit x5 into 4-bit words).
module tb_shadow_dump_ctrl;

  localparam int SA = 4, LA = 8, WA = 16, TA = 10;
  localparam int SB = 1, LB = 5, WB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, busy_a, done_a, err_a, c_en_a, d_en_a;
  logic          chain_ready_a = 1'b0;
  logic [SA-1:0] chain_out_a;
  logic [WA-1:0] dout_a;
  logic          dout_valid_a, dout_ready_a = 1'b1, dout_last_a;

  logic          start_b = 1'b0, busy_b, done_b, err_b, c_en_b, d_en_b;
  logic          chain_ready_b = 1'b0;
  logic [SB-1:0] chain_out_b;
  logic [WB-1:0] dout_b;
  logic          dout_valid_b, dout_ready_b = 1'b1, dout_last_b;

  logic ready_allow = 1'b1;
  int   checks = 0, errors = 0;

  shadow_dump_ctrl #(.SIZE(SA), .CHAIN_LEN(LA), .OUT_W(WA), .TIMEOUT(TA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .err(err_a),
    .c_en(c_en_a), .d_en(d_en_a), .chain_ready(chain_ready_a), .chain_out(chain_out_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready_a), .dout_last(dout_last_a)
  );

  shadow_dump_ctrl #(.SIZE(SB), .CHAIN_LEN(LB), .OUT_W(WB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .err(err_b),
    .c_en(c_en_b), .d_en(d_en_b), .chain_ready(chain_ready_b), .chain_out(chain_out_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready_b), .dout_last(dout_last_b)
  );

  // Chain models: capture loads the pattern and clears ready, which returns
  // a few cycles later; each dump edge shifts one element toward the tail.
  logic [SA-1:0] chain_a [LA];
  logic [SA-1:0] pat_a   [LA];
  int            rdy_cnt_a = 0;
  assign chain_out_a = chain_a[0];
  always @(posedge clk) begin
    if (c_en_a) begin
      for (int i = 0; i < LA; i++) chain_a[i] <= pat_a[i];
      chain_ready_a <= 1'b0;
      rdy_cnt_a     <= 3;
    end else begin
      if (rdy_cnt_a != 0) rdy_cnt_a <= rdy_cnt_a - 1;
      else if (ready_allow) chain_ready_a <= 1'b1;
      if (d_en_a) begin
        for (int i = 0; i < LA - 1; i++) chain_a[i] <= chain_a[i+1];
        chain_a[LA-1] <= '0;
      end
    end
  end

  logic [SB-1:0] chain_b [LB];
  logic [SB-1:0] pat_b   [LB];
  int            rdy_cnt_b = 0;
  assign chain_out_b = chain_b[0];
  always @(posedge clk) begin
    if (c_en_b) begin
      for (int i = 0; i < LB; i++) chain_b[i] <= pat_b[i];
      chain_ready_b <= 1'b0;
      rdy_cnt_b     <= 3;
    end else begin
      if (rdy_cnt_b != 0) rdy_cnt_b <= rdy_cnt_b - 1;
      else if (ready_allow) chain_ready_b <= 1'b1;
      if (d_en_b) begin
        for (int i = 0; i < LB - 1; i++) chain_b[i] <= chain_b[i+1];
        chain_b[LB-1] <= '0;
      end
    end
  end

  // Monitors record accepted words and enable/pulse activity.
  logic [WA-1:0] words_a [$];
  logic          lasts_a [$];
  int            runs_a  [$];
  int            run_a = 0, den_a = 0, done_cnt_a = 0, err_cnt_a = 0, vld_a = 0;
  always @(negedge clk) begin
    if (dout_valid_a && dout_ready_a) begin
      words_a.push_back(dout_a);
      lasts_a.push_back(dout_last_a);
    end
    if (d_en_a) begin
      den_a++;
      run_a++;
    end else if (run_a > 0) begin
      runs_a.push_back(run_a);
      run_a = 0;
    end
    if (done_a) done_cnt_a++;
    if (err_a) err_cnt_a++;
    if (dout_valid_a) vld_a++;
  end

  logic [WB-1:0] words_b [$];
  logic          lasts_b [$];
  int            den_b = 0, done_cnt_b = 0;
  always @(negedge clk) begin
    if (dout_valid_b && dout_ready_b) begin
      words_b.push_back(dout_b);
      lasts_b.push_back(dout_last_b);
    end
    if (d_en_b) den_b++;
    if (done_b) done_cnt_b++;
  end

  typedef struct {
    string       nm;
    logic [15:0] word;
    logic        last;
  } wvec_t;
  wvec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_words_a(input string nm, input int qbase, input int tbase, input int n);
    chk({nm, "_nwords"}, words_a.size() - qbase, n);
    for (int i = 0; i < n; i++) begin
      if (qbase + i < words_a.size()) begin
        chk({nm, "_", tbl[tbase+i].nm}, 32'(words_a[qbase+i]), 32'(tbl[tbase+i].word));
        chk({nm, "_", tbl[tbase+i].nm, "_last"}, 32'(lasts_a[qbase+i]), 32'(tbl[tbase+i].last));
      end
    end
  endtask

  task automatic pulse_start_a(input string nm);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    chk({nm, "_c_en_t1"}, c_en_a, 1);
  endtask

  task automatic wait_done_a(input string nm);
    int n;
    n = 0;
    while (!done_a && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_done_seen"}, done_a, 1);
    chk({nm, "_busy_at_done"}, busy_a, 0);
  endtask

  task automatic run_a_full(input string nm, input bit stall, input bit poke);
    int qa, da, dn, ea, ra, n;
    qa = words_a.size(); da = den_a; dn = done_cnt_a; ea = err_cnt_a; ra = runs_a.size();
    pulse_start_a(nm);
    if (stall) begin
      n = 0;
      while (!dout_valid_a && n < 100) begin @(posedge clk); #1; n++; end
      chk({nm, "_first_valid"}, dout_valid_a, 1);
      dout_ready_a = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      chk({nm, "_stall_dout"}, dout_a, 16'h4321);
      chk({nm, "_stall_valid"}, dout_valid_a, 1);
      chk({nm, "_stall_last"}, dout_last_a, 0);
      chk({nm, "_stall_den"}, d_en_a, 0);
      @(posedge clk); #1 dout_ready_a = 1'b1;
    end
    if (poke) begin
      n = 0;
      while (!d_en_a && n < 100) begin @(posedge clk); #1; n++; end
      chk({nm, "_den_seen"}, d_en_a, 1);
      start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
    end
    wait_done_a(nm);
    @(posedge clk); #1;
    chk({nm, "_idle_after"}, busy_a, 0);
    check_words_a(nm, qa, 0, 2);
    chk({nm, "_den_cycles"}, den_a - da, 8);
    chk({nm, "_den_runs"}, runs_a.size() - ra, 1);
    chk({nm, "_run_len"}, (runs_a.size() > ra) ? runs_a[ra] : 0, 8);
    chk({nm, "_done_pulses"}, done_cnt_a - dn, 1);
    chk({nm, "_err_pulses"}, err_cnt_a - ea, 0);
  endtask

  initial begin
    int n, da, va, ea;
    bit early;

    tbl[0] = '{"w0", 16'h4321, 1'b0};
    tbl[1] = '{"w1", 16'h8765, 1'b1};
    tbl[2] = '{"w0", 16'h000D, 1'b0};
    tbl[3] = '{"w1", 16'h0001, 1'b1};
    for (int i = 0; i < LA; i++) pat_a[i] = SA'(i + 1);
    pat_b[0] = 1'b1; pat_b[1] = 1'b0; pat_b[2] = 1'b1; pat_b[3] = 1'b1; pat_b[4] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_c_en", c_en_a, 0);
    chk("rst_d_en", d_en_a, 0);
    chk("rst_valid", dout_valid_a, 0);
    chk("rst_last", dout_last_a, 0);
    chk("rst_dout", dout_a, 0);
    rst = 1'b0;

    run_a_full("a_basic", 1'b0, 1'b0);

    // Odd-length 1-bit chain: second word is zero-padded.
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    chk("b_c_en_t1", c_en_b, 1);
    n = 0;
    while (!done_b && n < 300) begin @(posedge clk); #1; n++; end
    chk("b_done_seen", done_b, 1);
    @(posedge clk); #1;
    chk("b_nwords", words_b.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < words_b.size()) begin
        chk({"b_", tbl[2+i].nm}, 32'(words_b[i]), 32'(tbl[2+i].word));
        chk({"b_", tbl[2+i].nm, "_last"}, 32'(lasts_b[i]), 32'(tbl[2+i].last));
      end
    end
    chk("b_den_cycles", den_b, 5);
    chk("b_done_pulses", done_cnt_b, 1);
    chk("b_err", err_b, 0);

    run_a_full("a_stall", 1'b1, 1'b0);
    run_a_full("a_poke", 1'b0, 1'b1);

    // WAIT timeout: ready never returns after the capture pulse.
    ready_allow = 1'b0;
    da = den_a; va = vld_a; ea = err_cnt_a;
    pulse_start_a("a_tmo");
    @(posedge clk); #1;
    early = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i < 10 && (done_a || err_a)) early = 1'b1;
    end
    chk("a_tmo_early_done", early, 0);
    chk("a_tmo_done", done_a, 1);
    chk("a_tmo_err", err_a, 1);
    chk("a_tmo_busy", busy_a, 0);
    @(posedge clk); #1;
    chk("a_tmo_done_width", done_a, 0);
    chk("a_tmo_den", den_a - da, 0);
    chk("a_tmo_valid", vld_a - va, 0);
    chk("a_tmo_err_pulses", err_cnt_a - ea, 1);
    ready_allow = 1'b1;

    // Asynchronous reset on the third dump cycle, then a clean rerun.
    pulse_start_a("a_rst");
    n = 0;
    while (!d_en_a && n < 100) begin @(posedge clk); #1; n++; end
    chk("a_rst_den_seen", d_en_a, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("a_rst_async_den", d_en_a, 0);
    chk("a_rst_async_valid", dout_valid_a, 0);
    chk("a_rst_async_busy", busy_a, 0);
    @(posedge clk); #1 rst = 1'b0;
    run_a_full("a_after_rst", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
